// File: rtl/fdpe_delay_line_pkg.sv
// Shared constants and helpers for the fdpe_delay_line tapped shift register.
// Defaults live here so the top and the bench agree on one set of values.
package fdpe_delay_line_pkg;

    localparam int          DEF_WIDTH = 8;
    localparam int          DEF_DEPTH = 16;
    localparam logic [63:0] DEF_INIT  = '1;

    // Bits needed to index n items (0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fdpe_word.sv
// One WIDTH-bit stage of the delay line: async preset to INIT, clock enable.
module fdpe_word #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             C,
    input  logic             PRE,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge C or posedge PRE) begin
        if (PRE) begin
            word_q <= INIT;
        end else if (CE) begin
            word_q <= D;
        end
    end

    assign Q = word_q;

endmodule

// File: rtl/fdpe_delay_line.sv
// Tapped delay line of DEPTH fdpe_word stages with a saturating fill counter,
// clamped tap select and optional registered tap output.
module fdpe_delay_line
    import fdpe_delay_line_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] INIT    = DEF_INIT[WIDTH-1:0],
    parameter int               REG_OUT = 0,
    localparam int              AW      = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1
) (
    input  logic             C,
    input  logic             PRE,
    input  logic             CE,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    A,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_LAST,
    output logic             VALID,
    output logic             FULL
);

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [AW:0]      fill_q;
    logic [AW:0]      fill_d;
    logic [AW-1:0]    ea;
    logic [WIDTH-1:0] tap;
    logic             tap_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            fdpe_word #(.WIDTH(WIDTH), .INIT(INIT)) u_word (
                .C   (C),
                .PRE (PRE),
                .CE  (CE),
                .D   (D),
                .Q   (stage[i])
            );
        end else begin : g_body
            fdpe_word #(.WIDTH(WIDTH), .INIT(INIT)) u_word (
                .C   (C),
                .PRE (PRE),
                .CE  (CE),
                .D   (stage[i-1]),
                .Q   (stage[i])
            );
        end
    end

    // Counter saturates at DEPTH so FULL and VALID stay true on long runs.
    always_comb begin
        fill_d = fill_q;
        if (CE && (fill_q != DEPTH_W)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge C or posedge PRE) begin
        if (PRE) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Out-of-range selects clamp to the last stage rather than reading X.
    always_comb begin
        ea = LAST_IDX;
        if ({1'b0, A} < DEPTH_W) begin
            ea = A;
        end
    end

    assign tap       = stage[ea];
    assign tap_valid = (fill_q > {1'b0, ea});
    assign Q_LAST    = stage[DEPTH-1];
    assign FULL      = (fill_q == DEPTH_W);

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] q_out_q;
        logic             valid_out_q;

        // Output register samples every edge, independent of CE.
        always_ff @(posedge C or posedge PRE) begin
            if (PRE) begin
                q_out_q     <= INIT;
                valid_out_q <= 1'b0;
            end else begin
                q_out_q     <= tap;
                valid_out_q <= tap_valid;
            end
        end

        assign Q     = q_out_q;
        assign VALID = valid_out_q;
    end else begin : g_comb_out
        assign Q     = tap;
        assign VALID = tap_valid;
    end

endmodule

// File: tb/tb_fdpe_delay_line.sv
// Directed bench for fdpe_delay_line: combinational taps at DEPTH 16 and 12,
// and a registered-output instance, all sharing clock, preset, enable and data.
module tb_fdpe_delay_line;

    logic       C;
    logic       PRE;
    logic       CE;
    logic [7:0] D;

    logic [3:0] a0, a1, a2;
    logic [7:0] q0, q1, q2, ql0, ql1, ql2;
    logic       v0, v1, v2, f0, f1, f2;

    int n_checks;
    int n_fail;

    fdpe_delay_line #(.WIDTH(8), .DEPTH(16), .INIT(8'hFF), .REG_OUT(0)) dut0 (
        .C(C), .PRE(PRE), .CE(CE), .D(D), .A(a0),
        .Q(q0), .Q_LAST(ql0), .VALID(v0), .FULL(f0)
    );

    fdpe_delay_line #(.WIDTH(8), .DEPTH(12), .INIT(8'hFF), .REG_OUT(0)) dut1 (
        .C(C), .PRE(PRE), .CE(CE), .D(D), .A(a1),
        .Q(q1), .Q_LAST(ql1), .VALID(v1), .FULL(f1)
    );

    fdpe_delay_line #(.WIDTH(8), .DEPTH(16), .INIT(8'hFF), .REG_OUT(1)) dut2 (
        .C(C), .PRE(PRE), .CE(CE), .D(D), .A(a2),
        .Q(q2), .Q_LAST(ql2), .VALID(v2), .FULL(f2)
    );

    // clock / reset
    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic pulse_pre();
        PRE = 1'b1;
        #1;
        PRE = 1'b0;
        #1;
    endtask

    task automatic shift(input logic [7:0] val);
        D  = val;
        CE = 1'b1;
        tick();
        CE = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        PRE = 1'b1;
        CE  = 1'b0;
        D   = 8'h00;
        a0  = 4'd3;
        a1  = 4'd15;
        a2  = 4'd0;
        #3;

        check("rst_q0", q0, 8'hFF);
        check("rst_qlast0", ql0, 8'hFF);
        check("rst_valid0", v0, 1'b0);
        check("rst_full0", f0, 1'b0);
        check("rst_q2", q2, 8'hFF);
        check("rst_valid2", v2, 1'b0);

        // Clock and enable are ignored while preset is held.
        CE = 1'b1;
        D  = 8'h77;
        tick();
        check("pre_hold_qlast0", ql0, 8'hFF);
        check("pre_hold_full0", f0, 1'b0);
        check("pre_hold_q0", q0, 8'hFF);
        PRE = 1'b0;
        CE  = 1'b0;

        // 16 shifts of 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            D  = 8'(k);
            CE = 1'b1;
            tick();
        end
        CE = 1'b0;
        check("fill16_q0", q0, 8'h0D);
        check("fill16_qlast0", ql0, 8'h01);
        check("fill16_valid0", v0, 1'b1);
        check("fill16_full0", f0, 1'b1);
        check("clamp_q1", q1, 8'h05);
        check("clamp_qlast1", ql1, 8'h05);
        check("clamp_valid1", v1, 1'b1);
        check("clamp_full1", f1, 1'b1);
        check("regout_q2", q2, 8'h0F);
        a0 = 4'd7;
        #1;
        check("tap_change_q0", q0, 8'h09);

        // Partial fill: unwritten taps read INIT and are not valid.
        pulse_pre();
        shift(8'h55);
        shift(8'hAA);
        a0 = 4'd5;
        #1;
        check("partial_q0_a5", q0, 8'hFF);
        check("partial_valid0_a5", v0, 1'b0);
        check("partial_full0", f0, 1'b0);
        a0 = 4'd1;
        #1;
        check("partial_q0_a1", q0, 8'h55);
        check("partial_valid0_a1", v0, 1'b1);
        a0 = 4'd0;
        #1;
        check("partial_q0_a0", q0, 8'hAA);

        // Fill 4, hold CE low for 10 edges, then asynchronous preset.
        pulse_pre();
        shift(8'h11);
        shift(8'h22);
        shift(8'h33);
        shift(8'h44);
        a0 = 4'd3;
        for (int k = 0; k < 10; k++) begin
            D = 8'(8'hE0 + k);
            tick();
        end
        check("hold_q0", q0, 8'h11);
        check("hold_qlast0", ql0, 8'hFF);
        check("hold_valid0", v0, 1'b1);
        a0 = 4'd4;
        #1;
        check("hold_fill_valid0_a4", v0, 1'b0);
        a0 = 4'd3;
        PRE = 1'b1;
        #1;
        check("async_pre_q0", q0, 8'hFF);
        check("async_pre_valid0", v0, 1'b0);
        check("async_pre_q2", q2, 8'hFF);
        check("async_pre_valid2", v2, 1'b0);
        PRE = 1'b0;
        #1;

        // First enabled edge after preset loads stage 0, fill becomes 1.
        shift(8'h5A);
        a0 = 4'd0;
        #1;
        check("post_pre_q0", q0, 8'h5A);
        check("post_pre_valid0_a0", v0, 1'b1);
        a0 = 4'd1;
        #1;
        check("post_pre_valid0_a1", v0, 1'b0);

        // Registered output: one extra edge of latency for Q and VALID.
        pulse_pre();
        a2 = 4'd0;
        shift(8'h3C);
        check("regout_lat_q2_e1", q2, 8'hFF);
        check("regout_lat_valid2_e1", v2, 1'b0);
        tick();
        check("regout_lat_q2_e2", q2, 8'h3C);
        check("regout_lat_valid2_e2", v2, 1'b1);

        // 40 shifts: counter saturates, never wraps.
        pulse_pre();
        a0 = 4'd15;
        for (int k = 1; k <= 40; k++) begin
            D  = 8'(k);
            CE = 1'b1;
            tick();
            if (k == 16 || k == 32 || k == 40) begin
                check($sformatf("sat_full0_k%0d", k), f0, 1'b1);
                check($sformatf("sat_valid0_k%0d", k), v0, 1'b1);
            end
        end
        CE = 1'b0;
        check("sat_qlast0", ql0, 8'h19);
        check("sat_q0", q0, 8'h19);
        check("sat_full1", f1, 1'b1);
        check("sat_full2", f2, 1'b1);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fdpe_delay_line.md
FDPE_DELAY_LINE -- requirements
Module: fdpe_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (valid range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of shift stages (valid range 2..256).
REQ-003 The block SHALL have parameter INIT, default all-ones of WIDTH bits, giving the value every stage and output register takes on preset.
REQ-004 The block SHALL have parameter REG_OUT, default 0: 0 = combinational tap output, 1 = registered tap output.
REQ-005 The block SHALL define localparam AW = max(1, ceil(log2(DEPTH))).
REQ-006 Port C: input, 1 bit, the single clock; all state SHALL change on its rising edge only.
REQ-007 Port PRE: input, 1 bit, asynchronous active-high preset (reset), dominant over C and CE.
REQ-008 Port CE: input, 1 bit, clock enable for the shift operation.
REQ-009 Port D: input, WIDTH bits, data shifted into stage 0.
REQ-010 Port A: input, AW bits, tap select; stage A is presented on Q.
REQ-011 Port Q: output, WIDTH bits, selected tap data.
REQ-012 Port Q_LAST: output, WIDTH bits, contents of stage DEPTH-1 (always combinational from the stage).
REQ-013 Port VALID: output, 1 bit, high when the selected tap holds a word shifted in since the last preset.
REQ-014 Port FULL: output, 1 bit, high when all DEPTH stages hold post-preset data.

Function
REQ-015 On a rising C with PRE low and CE high: stage0 <= D, stage[i] <= stage[i-1] for i = 1..DEPTH-1, all in the same edge.
REQ-016 With CE low, stages and the fill counter SHALL hold.
REQ-017 Fill counter: width AW+1; increments by 1 on each enabled shift; saturates at DEPTH; never wraps.
REQ-018 Effective tap index: ea = A when A < DEPTH, otherwise DEPTH-1 (clamp; out-of-range A SHALL never produce X).
REQ-019 REG_OUT=0: Q = stage[ea] and VALID = (fill > ea), both combinational; latency from D to Q SHALL be ea+1 enabled edges.
REQ-020 REG_OUT=1: on every rising C with PRE low (independent of CE), Q <= stage[ea] and VALID <= (fill > ea), using pre-edge state; latency SHALL be one additional C edge.
REQ-021 FULL = (fill == DEPTH), combinational from the counter, in both modes.
REQ-022 A change of A SHALL take effect on Q immediately (REG_OUT=0) or at the next C edge (REG_OUT=1), without disturbing stage contents.

Reset
REQ-023 PRE high SHALL, asynchronously and without waiting for C, set every stage and the Q register to INIT, and fill to 0.
REQ-024 While PRE is high: Q = INIT, Q_LAST = INIT, VALID = 0, FULL = 0; C and CE SHALL be ignored.
REQ-025 PRE asserted mid-operation SHALL discard all contents; the first enabled edge after PRE falls SHALL load stage0 and set fill to 1.
REQ-026 PRE and a rising C arriving simultaneously SHALL resolve to the preset result.

Structure
REQ-027 The stage array SHALL be built from one sub-module, fdpe_word (WIDTH-bit register with async preset to INIT and clock enable), instantiated DEPTH times.
REQ-028 A shared package SHALL hold the clog2 function and the default INIT/WIDTH/DEPTH constants; no other typedefs are required.
REQ-029 The fill counter and output register SHALL live in the top module, and no latches SHALL be inferred.

Verification
REQ-030 WIDTH=8, DEPTH=16, REG_OUT=0: PRE pulse, then CE=1 with D=0x01..0x10 on 16 edges, A=3 -> Q=0x0D, Q_LAST=0x01, VALID=1, FULL=1.
REQ-031 After PRE, 2 enabled shifts of D=0x55,0xAA with A=5 -> Q=0xFF (INIT), VALID=0, FULL=0; A=1 -> Q=0x55, VALID=1.
REQ-032 Fill 4 words, then hold CE low for 10 edges -> Q, Q_LAST and fill unchanged; then PRE asserted between edges -> Q=0xFF and VALID=0 immediately, before any C edge.
REQ-033 DEPTH=16, A driven to 20 (AW=4 truncates; use DEPTH=12, A=15) -> Q equals stage 11, no X.
REQ-034 REG_OUT=1, A=0, D=0x3C on one enabled edge -> Q stays INIT after that edge and becomes 0x3C after the next edge (CE low); VALID follows with the same one-edge delay.
REQ-035 Run 40 enabled shifts -> fill saturates at 16, FULL stays 1, and no wrap to 0 occurs.
